// File: rtl/config_mux_chain.sv
// Serially configured bit mux: a scan-style config chain selects one data_in bit, optionally registered.
// data_out is zero-latency in combinational mode and one-cycle latency in registered mode; config_out lags config_in by CFG_WIDTH shifts.
module config_mux_chain #(
  parameter int DATA_WIDTH = 5,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_out,
  input  logic                  config_enable,
  input  logic                  config_in,
  output logic                  config_out,
  output logic                  configured
);

  localparam int CFG_WIDTH = SEL_WIDTH + 1;
  localparam int CNT_WIDTH = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CFG_WIDTH - 1);

  typedef enum logic {
    UNCONFIGURED = 1'b0,
    ACTIVE       = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CFG_WIDTH-1:0]   cfg_shift_q, cfg_shift_d;
  logic [CFG_WIDTH-1:0]   cfg_active_q, cfg_active_d;
  logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   data_reg_q, data_reg_d;
  logic                   commit;
  logic                   mux_bit;
  logic [SEL_WIDTH-1:0]   sel;
  logic                   mode_reg;

  assign sel      = cfg_active_q[SEL_WIDTH-1:0];
  assign mode_reg = cfg_active_q[SEL_WIDTH];

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q      <= UNCONFIGURED;
      cfg_shift_q  <= '0;
      cfg_active_q <= '0;
      bit_cnt_q    <= '0;
      data_reg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_active_q <= cfg_active_d;
      bit_cnt_q    <= bit_cnt_d;
      data_reg_q   <= data_reg_d;
    end
  end

  // A paused load simply holds bit_cnt; only the final shift of a word commits it.
  always_comb begin
    cfg_shift_d  = cfg_shift_q;
    cfg_active_d = cfg_active_q;
    bit_cnt_d    = bit_cnt_q;
    state_d      = state_q;
    commit       = 1'b0;
    if (config_enable) begin
      cfg_shift_d = {config_in, cfg_shift_q[CFG_WIDTH-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        commit       = 1'b1;
        bit_cnt_d    = '0;
        cfg_active_d = cfg_shift_d;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
      end
    end
    case (state_q)
      UNCONFIGURED: if (commit) state_d = ACTIVE;
      ACTIVE:       state_d = ACTIVE;
      default:      state_d = UNCONFIGURED;
    endcase
  end

  // Selectors beyond the last data input fall through to zero.
  always_comb begin
    mux_bit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(sel) == i) mux_bit = data_in[i];
    end
  end

  assign data_reg_d = commit ? 1'b0 : mux_bit;

  assign configured = (state_q == ACTIVE);
  assign config_out = cfg_shift_q[0];
  assign data_out   = !configured ? 1'b0 : (mode_reg ? data_reg_q : mux_bit);

endmodule

// File: tb/tb_config_mux_chain.sv
// Directed bench for config_mux_chain with a queue-based reference model checked every cycle.
module tb_config_mux_chain;

  logic       clock;
  logic       nreset;
  logic [4:0] data_in;
  logic       data_out;
  logic       config_enable;
  logic       config_in;
  logic       config_out;
  logic       configured;

  int n_checks = 0;
  int n_fail   = 0;

  config_mux_chain #(.DATA_WIDTH(5), .SEL_WIDTH(3)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .data_in       (data_in),
    .data_out      (data_out),
    .config_enable (config_enable),
    .config_in     (config_in),
    .config_out    (config_out),
    .configured    (configured)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: every bit shifted since reset, the last committed word, and the output flop.
  logic       hist[$];
  logic [3:0] m_word;
  logic       m_cfg;
  logic       m_reg;
  logic       m_valid = 1'b0;
  logic       m_commit;
  int         m_n;

  function automatic logic mux_of(input logic [3:0] w, input logic [4:0] d);
    int s;
    s = int'(w[2:0]);
    return (s < 5) ? d[s] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (!nreset) begin
      hist.delete();
      m_word  = 4'b0;
      m_cfg   = 1'b0;
      m_reg   = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_commit = 1'b0;
      if (config_enable) begin
        hist.push_back(config_in);
        if (hist.size() % 4 == 0) m_commit = 1'b1;
      end
      m_reg = m_commit ? 1'b0 : mux_of(m_word, data_in);
      if (m_commit) begin
        m_n    = hist.size();
        m_word = {hist[m_n-1], hist[m_n-2], hist[m_n-3], hist[m_n-4]};
        m_cfg  = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    logic exp_out;
    logic exp_cout;
    int   n;
    #2;
    if (m_valid) begin
      exp_out  = !m_cfg ? 1'b0 : (m_word[3] ? m_reg : mux_of(m_word, data_in));
      n        = hist.size();
      exp_cout = (n >= 4) ? hist[n-4] : 1'b0;
      chk("model_data_out", data_out, exp_out);
      chk("model_config_out", config_out, exp_cout);
      chk("model_configured", configured, m_cfg);
    end
  end

  task automatic step(input logic en, input logic cin, input logic [4:0] din, input logic rst);
    @(negedge clock);
    config_enable = en;
    config_in     = cin;
    data_in       = din;
    nreset        = rst;
    #1;
  endtask

  task automatic load_word(input logic [3:0] w, input logic [4:0] din);
    for (int i = 0; i < 4; i++) step(1'b1, w[i], din, 1'b1);
  endtask

  initial begin
    nreset        = 1'b0;
    config_enable = 1'b0;
    config_in     = 1'b0;
    data_in       = 5'b0;

    step(1'b0, 1'b0, 5'b00000, 1'b0);
    step(1'b0, 1'b0, 5'b11111, 1'b1);
    chk("reset_configured", configured, 1'b0);
    chk("reset_data_out", data_out, 1'b0);
    chk("reset_config_out", config_out, 1'b0);

    // Combinational mode, selector 2
    load_word(4'b0010, 5'b00100);
    chk("comb_pre_commit_unconfigured", configured, 1'b0);
    step(1'b0, 1'b0, 5'b00100, 1'b1);
    chk("comb_configured", configured, 1'b1);
    chk("comb_sel2_hi", data_out, 1'b1);
    step(1'b0, 1'b0, 5'b11011, 1'b1);
    chk("comb_sel2_lo", data_out, 1'b0);

    // Out-of-range selector 6
    load_word(4'b0110, 5'b11111);
    step(1'b0, 1'b0, 5'b11111, 1'b1);
    chk("oor_all_ones", data_out, 1'b0);
    step(1'b0, 1'b0, 5'b01000, 1'b1);
    chk("oor_bit3", data_out, 1'b0);

    // Registered mode, selector 3
    load_word(4'b1011, 5'b01000);
    step(1'b0, 1'b0, 5'b01000, 1'b1);
    chk("reg_first_cycle_zero", data_out, 1'b0);
    step(1'b0, 1'b0, 5'b00000, 1'b1);
    chk("reg_lag_1", data_out, 1'b1);
    step(1'b0, 1'b0, 5'b01000, 1'b1);
    chk("reg_lag_0", data_out, 1'b0);
    step(1'b0, 1'b0, 5'b00000, 1'b1);
    chk("reg_lag_1b", data_out, 1'b1);
    step(1'b0, 1'b0, 5'b01000, 1'b1);
    chk("reg_lag_0b", data_out, 1'b0);

    // Pause and shadow reload: 0010 active, then 0001 loaded with a gap
    load_word(4'b0010, 5'b00100);
    step(1'b1, 1'b1, 5'b00100, 1'b1);
    chk("shadow_bit0_sel2", data_out, 1'b1);
    step(1'b1, 1'b0, 5'b00100, 1'b1);
    chk("shadow_bit1_sel2", data_out, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'b00100, 1'b1);
      chk("shadow_pause_sel2", data_out, 1'b1);
    end
    step(1'b1, 1'b0, 5'b00100, 1'b1);
    chk("shadow_bit2_sel2", data_out, 1'b1);
    step(1'b1, 1'b0, 5'b00100, 1'b1);
    chk("shadow_bit3_sel2", data_out, 1'b1);
    step(1'b0, 1'b0, 5'b00010, 1'b1);
    chk("shadow_commit_sel1_hi", data_out, 1'b1);
    step(1'b0, 1'b0, 5'b00100, 1'b1);
    chk("shadow_commit_sel1_lo", data_out, 1'b0);
    chk("shadow_still_configured", configured, 1'b1);

    // Chain passthrough: A = 1010 emerges while B = 0110 shifts in
    load_word(4'b1010, 5'b00000);
    step(1'b1, 1'b0, 5'b00000, 1'b1);
    chk("chain_a_b0", config_out, 1'b0);
    step(1'b1, 1'b1, 5'b00000, 1'b1);
    chk("chain_a_b1", config_out, 1'b1);
    step(1'b1, 1'b1, 5'b00000, 1'b1);
    chk("chain_a_b2", config_out, 1'b0);
    step(1'b1, 1'b0, 5'b00000, 1'b1);
    chk("chain_a_b3", config_out, 1'b1);
    step(1'b0, 1'b0, 5'b00000, 1'b1);
    chk("chain_b_b0", config_out, 1'b0);

    // Reset mid-load, with config_enable still high
    step(1'b1, 1'b1, 5'b11111, 1'b1);
    step(1'b1, 1'b1, 5'b11111, 1'b1);
    step(1'b1, 1'b1, 5'b11111, 1'b0);
    step(1'b0, 1'b0, 5'b11111, 1'b1);
    chk("midload_rst_configured", configured, 1'b0);
    chk("midload_rst_data_out", data_out, 1'b0);
    chk("midload_rst_config_out", config_out, 1'b0);
    load_word(4'b0001, 5'b00010);
    step(1'b0, 1'b0, 5'b00010, 1'b1);
    chk("fresh_load_configured", configured, 1'b1);
    chk("fresh_load_sel1", data_out, 1'b1);
    chk("fresh_load_config_out", config_out, 1'b1);
    step(1'b0, 1'b0, 5'b11101, 1'b1);
    chk("fresh_load_sel1_lo", data_out, 1'b0);
    step(1'b0, 1'b0, 5'b00000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
